adder_op_sched: RTL
===================

ADDER_OP_SCHED -- requirements
Module: adder_op_sched

Interface
REQ-001 Parameter OPQ_DEPTH, default 4, operand-queue entries (power of 2, 2..16).
REQ-002 Parameter RESQ_DEPTH, default 4, result-queue entries (power of 2, 2..16).
REQ-003 Parameter ADD_LAT, default 1, adder latency in cycles from operand change to valid add_out (0..7).
REQ-004 Parameter OP_ADDR, default 32'h0000_0600, operand push / result pop address.
REQ-005 Parameter STAT_ADDR, default 32'h0000_0604, status/clear address.
REQ-006 Parameter UNIMPL_VALUE, default 32'hDEAD_BEEF, read data for any other address.
REQ-007 clk_main_a0  in  1  sole clock; all logic on its rising edge.
REQ-008 rst_main_n_sync  in  1  reset, asynchronous assert, active-low.
REQ-009 wready  in  1  write strobe, one write per cycle high.
REQ-010 wr_addr  in  32  write address, qualified by wready.
REQ-011 wdata  in  32  write data, qualified by wready.
REQ-012 arvalid_q  in  1  read request.
REQ-013 araddr_q  in  32  read address, qualified by arvalid_q.
REQ-014 rready  in  1  host accepts read data.
REQ-015 rvalid  out  1  read data valid.
REQ-016 rdata  out  32  read data.
REQ-017 rresp  out  2  read response, always 2'b00.
REQ-018 add_in1  out  4  adder operand A (registered).
REQ-019 add_in2  out  4  adder operand B (registered).
REQ-020 add_out  in  5  adder sum.
REQ-021 busy  out  1  high when FSM not IDLE or operand queue non-empty.

Function
REQ-022 Write with wr_addr==OP_ADDR: push wdata[7:0] to operand queue if not full; if full, drop and set sticky ovf.
REQ-023 Write with wr_addr==STAT_ADDR and wdata[0]==1: clear ovf and unf next edge; other addresses ignored.
REQ-024 FSM states IDLE, WAIT, CAPTURE; encoding free.
REQ-025 IDLE->WAIT when operand queue non-empty and res_count<RESQ_DEPTH: same edge pops entry, add_in1<=entry[3:0], add_in2<=entry[7:4], loads latency counter with ADD_LAT.
REQ-026 WAIT: counter decrements each cycle; at 0 go CAPTURE (ADD_LAT==0 goes CAPTURE after one WAIT cycle).
REQ-027 CAPTURE: push {27'b0,add_out} to result queue, return IDLE; add_in1/add_in2 hold until next issue.
REQ-028 Issue-to-capture spacing ADD_LAT+2 edges; max throughput one op per ADD_LAT+3 cycles.
REQ-029 Result queue never overflows: slot reserved at issue (res_count + in-flight <= RESQ_DEPTH).
REQ-030 Read: when arvalid_q && !rvalid, next edge rvalid<=1, rresp<=0, rdata per REQ-031..033; arvalid_q ignored while rvalid high.
REQ-031 araddr_q==OP_ADDR: result queue non-empty -> rdata=head, pop; empty -> rdata=32'hDEAD_0000, set sticky unf.
REQ-032 araddr_q==STAT_ADDR: rdata={21'b0, unf, ovf, busy, res_count[3:0], opq_count[3:0]}.
REQ-033 Other addresses: rdata=UNIMPL_VALUE.
REQ-034 rvalid && rready: next edge rvalid<=0, rdata<=0.
REQ-035 Same-cycle push and pop on either queue allowed; count unchanged, FIFO order kept.
REQ-036 Same-cycle status read and clear: read returns pre-clear flags.
REQ-037 Same-cycle overflow event and clear: flag ends set (set wins).
REQ-038 Queue pointers wrap modulo depth; counts saturate never (guarded by full/empty).

Reset
REQ-039 On rst_main_n_sync low, immediately: rvalid=0, rdata=0, rresp=0, add_in1=0, add_in2=0, busy=0, FSM IDLE, both queues empty, ovf=unf=0.
REQ-040 Reset mid-operation discards in-flight op and all queued data; no result appears after deassertion.

Verification
REQ-041 Write OP_ADDR 8'h53 (ADD_LAT=1), wait 6 cycles, read OP_ADDR -> rdata 32'h0000_0008, rresp 0.
REQ-042 Write 8'hFF, 8'h21, 8'h00 back-to-back; three reads -> 32'h1E, 32'h03, 32'h00 in order.
REQ-043 Stall result reads, write 9 operands (depth 4) -> 4 results held, opq full, 9th dropped, status ovf=1; reads return first 8 sums in order.
REQ-044 Read OP_ADDR with empty queue -> 32'hDEAD_0000, status unf=1; write STAT_ADDR 32'h1 -> status bits 10:9 = 0.
REQ-045 Hold rready low 5 cycles after rvalid with arvalid_q pulsing -> rdata stable, no extra pop; rready high -> rvalid low next edge.
REQ-046 Assert reset during WAIT -> all outputs 0 asynchronously; after release, OP_ADDR read returns 32'hDEAD_0000.

Source files
------------

// File: rtl/adder_op_sched.sv
// adder_op_sched: register-mapped scheduler for an external 4-bit adder.
// The host pushes packed operand bytes into an operand queue. A small FSM
// issues one pair at a time to the adder, waits out its latency, then
// captures the sum into a result queue. The host pops results, or reads
// status, through a single-outstanding read channel.
// A result slot is always free at issue time, so a capture can never overflow.

module adder_op_sched #(
    parameter int unsigned OPQ_DEPTH    = 4,
    parameter int unsigned RESQ_DEPTH   = 4,
    parameter int unsigned ADD_LAT      = 1,
    parameter logic [31:0] OP_ADDR      = 32'h0000_0600,
    parameter logic [31:0] STAT_ADDR    = 32'h0000_0604,
    parameter logic [31:0] UNIMPL_VALUE = 32'hDEAD_BEEF
) (
    input  logic        clk_main_a0,
    input  logic        rst_main_n_sync,
    input  logic        wready,
    input  logic [31:0] wr_addr,
    input  logic [31:0] wdata,
    input  logic        arvalid_q,
    input  logic [31:0] araddr_q,
    input  logic        rready,
    output logic        rvalid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic [3:0]  add_in1,
    output logic [3:0]  add_in2,
    input  logic [4:0]  add_out,
    output logic        busy
);

    // Queue geometry. Both depths are powers of two, so the pointers wrap
    // naturally. The counts are 5 bits wide so that a depth of 16 fits.
    localparam int unsigned OPQ_AW  = (OPQ_DEPTH  > 1) ? $clog2(OPQ_DEPTH)  : 1;
    localparam int unsigned RESQ_AW = (RESQ_DEPTH > 1) ? $clog2(RESQ_DEPTH) : 1;
    localparam logic [4:0]  OPQ_FULL_CNT  = 5'(OPQ_DEPTH);
    localparam logic [4:0]  RESQ_FULL_CNT = 5'(RESQ_DEPTH);
    localparam logic [2:0]  LAT_INIT      = 3'(ADD_LAT);

    // Sequencer states.
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WAIT    = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;

    localparam logic [31:0] EMPTY_READ_VALUE = 32'hDEAD_0000;

    // Operand queue
    logic [7:0]          r_opq_mem [OPQ_DEPTH];
    logic [OPQ_AW-1:0]   r_opq_wptr;
    logic [OPQ_AW-1:0]   r_opq_rptr;
    logic [4:0]          r_opq_count;

    // Result queue
    logic [4:0]          r_resq_mem [RESQ_DEPTH];
    logic [RESQ_AW-1:0]  r_resq_wptr;
    logic [RESQ_AW-1:0]  r_resq_rptr;
    logic [4:0]          r_res_count;

    // Sequencer
    logic [1:0]          r_state;
    logic [2:0]          r_lat_cnt;
    logic [3:0]          r_add_in1;
    logic [3:0]          r_add_in2;

    // Sticky flags and the read channel
    logic                r_ovf;
    logic                r_unf;
    logic                r_rvalid;
    logic [31:0]         r_rdata;
    logic [1:0]          r_rresp;

    // Decoded events
    logic                w_op_wr;
    logic                w_opq_full;
    logic                w_opq_empty;
    logic                w_opq_push;
    logic                w_ovf_set;
    logic                w_flag_clr;
    logic                w_issue;
    logic                w_capture;
    logic                w_rd_accept;
    logic                w_rd_op;
    logic                w_res_empty;
    logic                w_res_pop;
    logic                w_unf_set;
    logic                w_busy;
    logic [7:0]          w_opq_head;
    logic [1:0]          w_state_nxt;
    logic [2:0]          w_lat_nxt;
    logic [31:0]         w_rd_data;

    assign w_opq_full  = (r_opq_count == OPQ_FULL_CNT);
    assign w_opq_empty = (r_opq_count == 5'd0);
    assign w_res_empty = (r_res_count == 5'd0);
    assign w_opq_head  = r_opq_mem[r_opq_rptr];

    // An operand write to a full queue is dropped and reported via ovf.
    assign w_op_wr     = wready && (wr_addr == OP_ADDR);
    assign w_opq_push  = w_op_wr && !w_opq_full;
    assign w_ovf_set   = w_op_wr && w_opq_full;
    assign w_flag_clr  = wready && (wr_addr == STAT_ADDR) && wdata[0];

    // Issue only when a result slot is free. Only one op is in flight, and
    // only outside IDLE, so res_count alone decides whether a slot is reserved.
    assign w_issue     = (r_state == ST_IDLE) && !w_opq_empty &&
                         (r_res_count < RESQ_FULL_CNT);
    assign w_capture   = (r_state == ST_CAPTURE);

    // A new read is taken only while no read data is outstanding.
    assign w_rd_accept = arvalid_q && !r_rvalid;
    assign w_rd_op     = w_rd_accept && (araddr_q == OP_ADDR);
    assign w_res_pop   = w_rd_op && !w_res_empty;
    assign w_unf_set   = w_rd_op && w_res_empty;

    assign w_busy      = (r_state != ST_IDLE) || !w_opq_empty;

    // Sequencer next-state and latency-counter logic
    always_comb begin
        w_state_nxt = r_state;
        w_lat_nxt   = r_lat_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_issue) begin
                    w_state_nxt = ST_WAIT;
                    w_lat_nxt   = LAT_INIT;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (r_lat_cnt == 3'd0) begin
                    w_state_nxt = ST_CAPTURE;
                end else begin
                    w_lat_nxt   = r_lat_cnt - 3'd1;
                end
            end
            ST_CAPTURE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_lat_nxt   = 3'd0;
            end
        endcase
    end

    // Read-data selection for a newly accepted read request
    always_comb begin
        w_rd_data = UNIMPL_VALUE;
        if (araddr_q == OP_ADDR) begin
            if (!w_res_empty) begin
                w_rd_data = {27'd0, r_resq_mem[r_resq_rptr]};
            end else begin
                w_rd_data = EMPTY_READ_VALUE;
            end
        end else if (araddr_q == STAT_ADDR) begin
            w_rd_data = {21'd0, r_unf, r_ovf, w_busy,
                         r_res_count[3:0], r_opq_count[3:0]};
        end else begin
            w_rd_data = UNIMPL_VALUE;
        end
    end

    // Sequencer state, latency counter and registered adder operands
    always_ff @(posedge clk_main_a0 or negedge rst_main_n_sync) begin
        if (!rst_main_n_sync) begin
            r_state   <= ST_IDLE;
            r_lat_cnt <= 3'd0;
            r_add_in1 <= 4'd0;
            r_add_in2 <= 4'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_lat_cnt <= w_lat_nxt;
            if (w_issue) begin
                r_add_in1 <= w_opq_head[3:0];
                r_add_in2 <= w_opq_head[7:4];
            end
        end
    end

    // Operand queue data storage (contents are meaningless while empty)
    always_ff @(posedge clk_main_a0) begin
        if (w_opq_push) begin
            r_opq_mem[r_opq_wptr] <= wdata[7:0];
        end
    end

    // Operand queue pointers and occupancy
    always_ff @(posedge clk_main_a0 or negedge rst_main_n_sync) begin
        if (!rst_main_n_sync) begin
            r_opq_wptr  <= '0;
            r_opq_rptr  <= '0;
            r_opq_count <= 5'd0;
        end else begin
            if (w_opq_push) begin
                r_opq_wptr <= r_opq_wptr + 1'b1;
            end
            if (w_issue) begin
                r_opq_rptr <= r_opq_rptr + 1'b1;
            end
            case ({w_opq_push, w_issue})
                2'b10:   r_opq_count <= r_opq_count + 5'd1;
                2'b01:   r_opq_count <= r_opq_count - 5'd1;
                default: r_opq_count <= r_opq_count;
            endcase
        end
    end

    // Result queue data storage; the capture always has a reserved slot
    always_ff @(posedge clk_main_a0) begin
        if (w_capture) begin
            r_resq_mem[r_resq_wptr] <= add_out;
        end
    end

    // Result queue pointers and occupancy
    always_ff @(posedge clk_main_a0 or negedge rst_main_n_sync) begin
        if (!rst_main_n_sync) begin
            r_resq_wptr <= '0;
            r_resq_rptr <= '0;
            r_res_count <= 5'd0;
        end else begin
            if (w_capture) begin
                r_resq_wptr <= r_resq_wptr + 1'b1;
            end
            if (w_res_pop) begin
                r_resq_rptr <= r_resq_rptr + 1'b1;
            end
            case ({w_capture, w_res_pop})
                2'b10:   r_res_count <= r_res_count + 5'd1;
                2'b01:   r_res_count <= r_res_count - 5'd1;
                default: r_res_count <= r_res_count;
            endcase
        end
    end

    // Sticky overflow/underflow flags; a same-cycle set beats a clear
    always_ff @(posedge clk_main_a0 or negedge rst_main_n_sync) begin
        if (!rst_main_n_sync) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (w_flag_clr) begin
                r_ovf <= 1'b0;
            end
            if (w_unf_set) begin
                r_unf <= 1'b1;
            end else if (w_flag_clr) begin
                r_unf <= 1'b0;
            end
        end
    end

    // Read channel: capture one response, hold it until the host accepts it
    always_ff @(posedge clk_main_a0 or negedge rst_main_n_sync) begin
        if (!rst_main_n_sync) begin
            r_rvalid <= 1'b0;
            r_rdata  <= 32'd0;
            r_rresp  <= 2'b00;
        end else if (w_rd_accept) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_rd_data;
            r_rresp  <= 2'b00;
        end else if (r_rvalid && rready) begin
            r_rvalid <= 1'b0;
            r_rdata  <= 32'd0;
        end
    end

    assign rvalid  = r_rvalid;
    assign rdata   = r_rdata;
    assign rresp   = r_rresp;
    assign add_in1 = r_add_in1;
    assign add_in2 = r_add_in2;
    assign busy    = w_busy;

endmodule
